// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : pipeline_ctrl
// | Purpose  : Stall/flush sequencer for a 5-stage pipeline. Resolves load-use,
// |            branch-operand, multiply/divide occupancy and data-memory wait
// |            hazards. Drives per-stage enables and bubble controls and keeps
// |            a saturating stall-cycle counter.
// | Options  : define PIPE_MDU_EN to build the multiply/divide occupancy FSM;
// |            without it mdu_start_EXE is ignored and mdu_busy is 0.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int MDU_LATENCY = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4:0]             rs_ID,
   input  logic [4:0]             rt_ID,
   input  logic                   use_rs_ID,
   input  logic                   use_rt_ID,
   input  logic                   branch_ID,
   input  logic                   branch_taken_ID,
   input  logic                   reg_write_EXE,
   input  logic                   mem_read_EXE,
   input  logic [4:0]             num_write_EXE,
   input  logic                   mem_read_MEM,
   input  logic [4:0]             num_write_MEM,
   input  logic                   mdu_start_EXE,
   input  logic                   mem_req_MEM,
   input  logic                   mem_ready,
   output logic                   pc_en,
   output logic                   if_id_en,
   output logic                   id_exe_en,
   output logic                   exe_mem_en,
   output logic                   mem_wb_en,
   output logic                   if_id_flush,
   output logic                   id_exe_flush,
   output logic                   exe_mem_flush,
   output logic                   mem_wb_flush,
   output logic                   mdu_busy,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   // A source only depends on a destination it reads, and $0 never carries data.
   function automatic logic src_match(input logic use_b, input logic [4:0] src,
                                      input logic [4:0] dst);
      return use_b && (src == dst) && (dst != 5'd0);
   endfunction

   logic w_mem_stall;
   logic w_mdu_stall;
   logic w_match_exe;
   logic w_match_mem;
   logic w_load_use;
   logic w_br_stall;

   assign w_mem_stall = mem_req_MEM & ~mem_ready;
   assign w_match_exe = src_match(use_rs_ID, rs_ID, num_write_EXE) |
                        src_match(use_rt_ID, rt_ID, num_write_EXE);
   assign w_match_mem = src_match(use_rs_ID, rs_ID, num_write_MEM) |
                        src_match(use_rt_ID, rt_ID, num_write_MEM);
   assign w_load_use  = mem_read_EXE & w_match_exe;
   // The ID comparator needs its operands now: an ALU result still in EXE or
   // load data still in MEM is not yet forwardable.
   assign w_br_stall  = branch_ID & ((reg_write_EXE & w_match_exe) |
                                     (mem_read_MEM & w_match_mem));

`ifdef PIPE_MDU_EN
   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_MDU = 1'b1
   } state_t;

   state_t     state_q;
   logic [7:0] count_q;
   logic       w_mdu_enter;

   // The first occupancy cycle is the RUN cycle itself, so the counter only
   // covers the remaining MDU_LATENCY-2 stalled cycles before the exit cycle.
   assign w_mdu_enter = (state_q == ST_RUN) && mdu_start_EXE &&
                        (MDU_LATENCY > 1) && !w_mem_stall;
   assign w_mdu_stall = w_mdu_enter || ((state_q == ST_MDU) && (count_q != 8'd0));

   // Multiply/divide occupancy sequencer; memory freezes pause the countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         count_q <= 8'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (w_mdu_enter) begin
                  state_q <= ST_MDU;
                  count_q <= 8'(MDU_LATENCY - 2);
               end
            end
            ST_MDU: begin
               if (count_q == 8'd0) begin
                  state_q <= ST_RUN;
               end else if (!w_mem_stall) begin
                  count_q <= count_q - 8'd1;
               end
            end
            default: begin
               state_q <= ST_RUN;
               count_q <= 8'd0;
            end
         endcase
      end
   end
`else
   logic w_unused_mdu;

   assign w_mdu_stall  = 1'b0;
   assign w_unused_mdu = &{1'b0, mdu_start_EXE, (MDU_LATENCY != 0)};
`endif

   assign mdu_busy = w_mdu_stall;

   // Only the highest-priority active stall cause shapes the stage controls.
   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_exe_en     = 1'b1;
      exe_mem_en    = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_exe_flush  = 1'b0;
      exe_mem_flush = 1'b0;
      mem_wb_flush  = 1'b0;
      if (w_mem_stall) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_exe_en    = 1'b0;
         exe_mem_en   = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (w_mdu_stall) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_exe_en     = 1'b0;
         exe_mem_flush = 1'b1;
      end else if (w_load_use || w_br_stall) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_exe_flush = 1'b1;
      end else if (branch_ID && branch_taken_ID) begin
         if_id_flush = 1'b1;
      end
   end

   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d;

   assign stall_cnt_d  = (!pc_en && (stall_cnt_q != {STALL_CNT_W{1'b1}})) ?
                         stall_cnt_q + 1'b1 : stall_cnt_q;
   assign stall_cycles = stall_cnt_q;

   // Saturating count of frozen-PC cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB). It sits beside the forwarding unit and resolves the hazards forwarding cannot cover: load-use, branch-operand-not-ready for the ID-stage comparator, multi-cycle multiply/divide occupancy of EXE, and data-memory wait states. It drives per-stage register enables and bubble-insert (flush) controls, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- MDU_LATENCY, 32: total EXE cycles a mult/div instruction occupies; legal range 1..255.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rs_ID, rt_ID  in  5  source register numbers of the ID instruction.
- use_rs_ID, use_rt_ID  in  1  ID instruction actually reads rs / rt.
- branch_ID  in  1  ID instruction is BEQ/BNE, compared in ID.
- branch_taken_ID  in  1  ID comparator result.
- reg_write_EXE, mem_read_EXE  in  1  EXE instruction writes a register / is a load.
- num_write_EXE  in  5  EXE destination register.
- mem_read_MEM  in  1  MEM instruction is a load.
- num_write_MEM  in  5  MEM destination register.
- mdu_start_EXE  in  1  EXE instruction is mult/div.
- mem_req_MEM, mem_ready  in  1  data-memory access in MEM / access completes this cycle.
- pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en  out  1  stage register load enables.
- if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush  out  1  load a bubble (NOP, all write enables 0) instead of the upstream value.
- mdu_busy  out  1  EXE held by the multiply/divide unit.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_en=0.

## Operation
- Match rule: a source matches destination d only if its use_* bit is 1, the register numbers are equal, and d≠0.
- Stall causes, evaluated combinationally in priority order:
  1. mem_stall = mem_req_MEM & ~mem_ready. pc_en, if_id_en, id_exe_en and exe_mem_en are 0; mem_wb_flush=1. The MDU counter holds.
  2. mdu_stall (see FSM). pc_en, if_id_en and id_exe_en are 0; exe_mem_flush=1.
  3. load_use: mem_read_EXE and either ID source matches num_write_EXE. pc_en and if_id_en are 0; id_exe_flush=1.
  4. br_stall: branch_ID and either
     - a source matches num_write_EXE with reg_write_EXE, or
     - a source matches num_write_MEM with mem_read_MEM.
     Same outputs as load_use. A load feeding a branch therefore stalls 2 cycles.
- Only the highest-priority active cause drives the outputs. All enables not named above are 1 and all flushes are 0.
- Taken branch: branch_ID & branch_taken_ID with no active stall cause asserts if_id_flush=1. No flush is asserted while stalled.
- FSM states: RUN, MDU. Reset state is RUN with count=0.
  - RUN → MDU: mdu_start_EXE, MDU_LATENCY>1 and no mem_stall. This cycle mdu_stall=1 and count is loaded with MDU_LATENCY-2.
  - MDU, count≠0: mdu_stall=1. count decrements unless mem_stall is active.
  - MDU, count=0: mdu_stall=0, return to RUN. mdu_start_EXE is ignored on this exit cycle, so the same instruction cannot retrigger.
  - mdu_busy = mdu_stall.
- stall_cycles increments every cycle pc_en=0 and holds at all-ones.

## Timing
- All enable/flush outputs are combinational from inputs and state, valid in the same cycle.
- Reset (asynchronous, any time, including mid-MDU):
  - FSM goes to RUN, count=0, stall_cycles=0.
  - With inputs idle: all enables 1, all flushes 0, mdu_busy 0.
- A mult/div instruction entering EXE at cycle t keeps EXE through cycle t+MDU_LATENCY-1 and advances on that cycle's edge. Each mem_stall cycle extends this by one.
- Load-use costs 1 bubble. A branch depending on an ALU instruction in EXE costs 1 cycle; a branch depending on a load in EXE costs 2 cycles.
- mem_ready is sampled every cycle. The first cycle with mem_ready=1 releases the freeze.

## Configuration
- PIPE_MDU_EN defined: the MDU FSM, count register and mdu_busy operate as above.
- PIPE_MDU_EN undefined: no FSM or count register; mdu_start_EXE is ignored; mdu_stall and mdu_busy are constant 0; MDU_LATENCY is unused.

## Test plan
- Load to $8 in EXE; ID reads rs=$8 with use_rs=1 → one cycle of pc_en=0, if_id_en=0, id_exe_flush=1; stall_cycles=1.
- Same case with num_write_EXE=0 → no stall (register-0 exclusion).
- Load to $9 in EXE; BEQ in ID reads rt=$9 → 2 consecutive stall cycles (first from EXE match, then from MEM match). Next cycle with branch_taken_ID=1 → if_id_flush=1 for exactly 1 cycle.
- MDU_LATENCY=4, mdu_start_EXE held → mdu_busy=1 for 3 cycles, exe_mem_flush=1 on those cycles, released on the 4th. Repeat with mem_stall for 2 cycles mid-sequence → mdu_busy lasts 5 cycles.
- mem_req_MEM=1 with mem_ready=0 for 3 cycles while a load-use hazard is present → only mem_stall outputs (mem_wb_flush=1, exe_mem_en=0) for those 3 cycles, then load_use for 1 cycle.
- Assert rst in MDU with count=2 → outputs immediately return to the idle reset values; stall_cycles=0. Build without PIPE_MDU_EN → mdu_busy stays 0 under mdu_start_EXE=1.
